// File: rtl/decrypt_stream_pkg.sv
// Shared definitions for the receive-side stream decryptor: session states and
// the default character width.
package decrypt_stream_pkg;

  localparam int N_DEFAULT = 7;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_INIT = 3'd2,
    RUN       = 3'd3,
    DRAIN     = 3'd4
  } state_e;

endpackage

// File: rtl/decrypt_stream_ks_fifo.sv
// Small synchronous FIFO that prefetches keystream characters ahead of the
// ciphertext they will be XORed with. DEPTH must be a power of two.
module ks_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/decrypt_stream.sv
// Receive-side stream decryptor: loads the key into the keystream generator,
// prefetches keystream, and XORs each ciphertext character into plaintext.
module decrypt_stream
  import decrypt_stream_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int KS_DEPTH = 4,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  password,
  output logic [N-1:0]  key_out,
  output logic          key_load,
  input  logic          ks_init_done,
  input  logic [N-1:0]  ks_data,
  input  logic          ks_valid,
  output logic          ks_ready,
  input  logic [N-1:0]  ct_data,
  input  logic          ct_last,
  input  logic          ct_valid,
  output logic          ct_ready,
  output logic [N-1:0]  pt_data,
  output logic          pt_last,
  output logic          pt_valid,
  input  logic          pt_ready,
  output logic          busy,
  output logic [CW-1:0] char_count
);

  state_e        state_q, state_d;
  logic [N-1:0]  key_q, key_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  pt_data_q, pt_data_d;
  logic          pt_last_q, pt_last_d;
  logic          pt_valid_q, pt_valid_d;

  logic          fifo_flush;
  logic          fifo_push;
  logic          fifo_pop;
  logic [N-1:0]  fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          ct_xfer;
  logic          pt_xfer;

  ks_fifo #(
    .DEPTH (KS_DEPTH),
    .WIDTH (N)
  ) u_ks_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (ks_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pt_xfer = pt_valid_q && pt_ready;

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    cnt_d      = cnt_q;
    pt_data_d  = pt_data_q;
    pt_last_d  = pt_last_q;
    pt_valid_d = pt_valid_q;
    fifo_flush = 1'b0;
    ks_ready   = 1'b0;
    ct_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          key_d      = password;
          cnt_d      = '0;
          fifo_flush = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        state_d = WAIT_INIT;
      end
      WAIT_INIT: begin
        // Prefetch may begin in the very cycle the generator reports ready.
        ks_ready = ks_init_done && !fifo_full;
        if (ks_init_done) state_d = RUN;
      end
      RUN: begin
        ks_ready = !fifo_full;
        ct_ready = !fifo_empty && (!pt_valid_q || pt_ready);
        if (ct_valid && ct_ready && ct_last) state_d = DRAIN;
      end
      DRAIN: begin
        // Leftover keystream belongs to this session only, so drop it on exit.
        if (pt_xfer) begin
          state_d    = IDLE;
          fifo_flush = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ct_xfer   = ct_valid && ct_ready;
    fifo_pop  = ct_xfer;
    fifo_push = ks_valid && ks_ready;

    if (ct_xfer) begin
      pt_data_d  = ct_data ^ fifo_head;
      pt_last_d  = ct_last;
      pt_valid_d = 1'b1;
      cnt_d      = cnt_q + 1'b1;
    end else if (pt_xfer) begin
      pt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      key_q      <= '0;
      cnt_q      <= '0;
      pt_data_q  <= '0;
      pt_last_q  <= 1'b0;
      pt_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      cnt_q      <= cnt_d;
      pt_data_q  <= pt_data_d;
      pt_last_q  <= pt_last_d;
      pt_valid_q <= pt_valid_d;
    end
  end

  assign key_out    = key_q;
  assign key_load   = (state_q == LOAD);
  assign busy       = (state_q != IDLE);
  assign pt_data    = pt_data_q;
  assign pt_last    = pt_last_q;
  assign pt_valid   = pt_valid_q;
  assign char_count = cnt_q;

endmodule

// File: tb/tb_decrypt_stream.sv
// Bench for decrypt_stream: a cycle table for the basic session, directed
// corner sequences, and randomized sessions against a queue-based model.
module tb_decrypt_stream;

  localparam int N        = 7;
  localparam int KS_DEPTH = 4;
  localparam int CW       = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  password = '0;
  logic [N-1:0]  key_out;
  logic          key_load;
  logic          ks_init_done = 1'b0;
  logic [N-1:0]  ks_data = '0;
  logic          ks_valid = 1'b0;
  logic          ks_ready;
  logic [N-1:0]  ct_data = '0;
  logic          ct_last = 1'b0;
  logic          ct_valid = 1'b0;
  logic          ct_ready;
  logic [N-1:0]  pt_data;
  logic          pt_last;
  logic          pt_valid;
  logic          pt_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] char_count;

  decrypt_stream #(.N(N), .KS_DEPTH(KS_DEPTH), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .password     (password),
    .key_out      (key_out),
    .key_load     (key_load),
    .ks_init_done (ks_init_done),
    .ks_data      (ks_data),
    .ks_valid     (ks_valid),
    .ks_ready     (ks_ready),
    .ct_data      (ct_data),
    .ct_last      (ct_last),
    .ct_valid     (ct_valid),
    .ct_ready     (ct_ready),
    .pt_data      (pt_data),
    .pt_last      (pt_last),
    .pt_valid     (pt_valid),
    .pt_ready     (pt_ready),
    .busy         (busy),
    .char_count   (char_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: accepted keystream in arrival order, expected plaintext
  // {last, data} in order, and characters accepted this session.
  logic [N-1:0]  m_ks[$];
  logic [N:0]    m_exp[$];
  logic [CW-1:0] m_cnt = '0;
  bit            prev_stall = 1'b0;
  logic [N-1:0]  prev_pt = '0;
  bit            ks_rand = 1'b0;

  typedef struct {
    logic st; logic [N-1:0] pw; logic init; logic kv; logic [N-1:0] kd;
    logic cv; logic [N-1:0] cd; logic cl; logic pr;
    logic [N-1:0] e_key; logic e_kl; logic e_busy; logic e_ksr; logic e_ctr;
    logic e_pv; logic [N-1:0] e_pd; logic e_pl; logic [CW-1:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(
    input logic st, input logic [N-1:0] pw, input logic init, input logic kv,
    input logic [N-1:0] kd, input logic cv, input logic [N-1:0] cd, input logic cl,
    input logic pr, input logic [N-1:0] e_key, input logic e_kl, input logic e_busy,
    input logic e_ksr, input logic e_ctr, input logic e_pv, input logic [N-1:0] e_pd,
    input logic e_pl, input logic [CW-1:0] e_cnt);
    vec_t v;
    v.st = st; v.pw = pw; v.init = init; v.kv = kv; v.kd = kd;
    v.cv = cv; v.cd = cd; v.cl = cl; v.pr = pr;
    v.e_key = e_key; v.e_kl = e_kl; v.e_busy = e_busy; v.e_ksr = e_ksr;
    v.e_ctr = e_ctr; v.e_pv = e_pv; v.e_pd = e_pd; v.e_pl = e_pl; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  task automatic monitor();
    logic [N-1:0] k;
    logic [N:0]   e;
    check("char_count", 64'(char_count), 64'(m_cnt));
    if (prev_stall) begin
      check("pt_hold_valid", 64'(pt_valid), 64'(1));
      check("pt_hold_data", 64'(pt_data), 64'(prev_pt));
    end
    check("ct_ready_without_ks", 64'(ct_ready && (m_ks.size() == 0)), 64'(0));
    check("ct_ready_into_stall", 64'(ct_ready && pt_valid && !pt_ready), 64'(0));
    check("ks_ready_when_full", 64'(ks_ready && (m_ks.size() >= KS_DEPTH)), 64'(0));
    if (pt_valid && pt_ready) begin
      if (m_exp.size() == 0) fail_now("pt_spurious");
      else begin
        e = m_exp.pop_front();
        check("pt_out", 64'({pt_last, pt_data}), 64'(e));
        if (e[N]) m_ks.delete();
      end
    end
    if (ct_valid && ct_ready && (m_ks.size() > 0)) begin
      k = m_ks.pop_front();
      m_exp.push_back({ct_last, ct_data ^ k});
      m_cnt = m_cnt + 1'b1;
    end
    if (ks_valid && ks_ready) m_ks.push_back(ks_data);
    if (start && !busy) begin
      m_ks.delete();
      m_exp.delete();
      m_cnt = '0;
    end
    prev_stall = pt_valid && !pt_ready;
    prev_pt    = pt_data;
  endtask

  task automatic smp();
    @(negedge clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    if (ks_rand) ks_data = N'($urandom);
  endtask

  task automatic idle_inputs();
    start = 1'b0; ks_valid = 1'b0; ct_valid = 1'b0; ct_last = 1'b0;
    pt_ready = 1'b0; ks_init_done = 1'b0; ks_rand = 1'b0;
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b0;
    idle_inputs();
    #1;
    check({tag, "_reset_outs"},
          64'({key_out, key_load, ks_ready, ct_ready, pt_data, pt_last, pt_valid, busy, char_count}),
          64'(0));
    m_ks.delete();
    m_exp.delete();
    m_cnt = '0;
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic begin_session(input logic [N-1:0] pw, input int init_wait);
    password = pw;
    start = 1'b1;
    smp();
    adv();
    start = 1'b0;
    smp();
    check("sess_key_load", 64'(key_load), 64'(1));
    adv();
    for (int i = 0; i < init_wait; i++) begin
      smp();
      adv();
    end
    ks_init_done = 1'b1;
  endtask

  task automatic send_ct(input logic [N-1:0] d, input logic l);
    int n = 0;
    ct_valid = 1'b1;
    ct_data = d;
    ct_last = l;
    forever begin
      smp();
      if (ct_ready) begin
        adv();
        break;
      end
      adv();
      n++;
      if (n > 50) begin
        fail_now("send_ct_timeout");
        break;
      end
    end
    ct_valid = 1'b0;
    ct_last = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    pt_ready = 1'b1;
    ct_valid = 1'b0;
    ks_valid = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      smp();
      if (!busy) done = 1'b1;
      adv();
    end
    check({tag, "_idle"}, 64'(done), 64'(1));
    check({tag, "_exp_drained"}, 64'(m_exp.size()), 64'(0));
  endtask

  vec_t tbl[8];

  initial begin
    int pushes;
    int idx;
    int len;
    bit fin;
    logic [N-1:0] pw_old;

    @(posedge clk);
    #1;
    apply_reset("init");

    // Basic session, cycle by cycle from the start pulse.
    tbl[0] = mk(1'b1,7'h2A,1'b0,1'b0,7'h00,1'b0,7'h00,1'b0,1'b0, 7'h00,1'b0,1'b0,1'b0,1'b0,1'b0,7'h00,1'b0,16'd0);
    tbl[1] = mk(1'b0,7'h2A,1'b0,1'b0,7'h00,1'b0,7'h00,1'b0,1'b0, 7'h2A,1'b1,1'b1,1'b0,1'b0,1'b0,7'h00,1'b0,16'd0);
    tbl[2] = mk(1'b0,7'h2A,1'b0,1'b0,7'h00,1'b0,7'h00,1'b0,1'b0, 7'h2A,1'b0,1'b1,1'b0,1'b0,1'b0,7'h00,1'b0,16'd0);
    tbl[3] = mk(1'b0,7'h2A,1'b1,1'b1,7'h15,1'b0,7'h00,1'b0,1'b0, 7'h2A,1'b0,1'b1,1'b1,1'b0,1'b0,7'h00,1'b0,16'd0);
    tbl[4] = mk(1'b0,7'h2A,1'b1,1'b1,7'h33,1'b1,7'h48,1'b0,1'b1, 7'h2A,1'b0,1'b1,1'b1,1'b1,1'b0,7'h00,1'b0,16'd0);
    tbl[5] = mk(1'b0,7'h2A,1'b1,1'b0,7'h00,1'b1,7'h5A,1'b1,1'b1, 7'h2A,1'b0,1'b1,1'b1,1'b1,1'b1,7'h5D,1'b0,16'd1);
    tbl[6] = mk(1'b0,7'h2A,1'b1,1'b0,7'h00,1'b0,7'h00,1'b0,1'b1, 7'h2A,1'b0,1'b1,1'b0,1'b0,1'b1,7'h69,1'b1,16'd2);
    tbl[7] = mk(1'b0,7'h2A,1'b1,1'b0,7'h00,1'b0,7'h00,1'b0,1'b1, 7'h2A,1'b0,1'b0,1'b0,1'b0,1'b0,7'h69,1'b1,16'd2);

    for (int i = 0; i < 8; i++) begin
      start = tbl[i].st; password = tbl[i].pw; ks_init_done = tbl[i].init;
      ks_valid = tbl[i].kv; ks_data = tbl[i].kd; ct_valid = tbl[i].cv;
      ct_data = tbl[i].cd; ct_last = tbl[i].cl; pt_ready = tbl[i].pr;
      smp();
      check($sformatf("basic_row%0d", i),
            64'({key_out, key_load, busy, ks_ready, ct_ready, pt_valid, pt_data, pt_last, char_count}),
            64'({tbl[i].e_key, tbl[i].e_kl, tbl[i].e_busy, tbl[i].e_ksr, tbl[i].e_ctr,
                 tbl[i].e_pv, tbl[i].e_pd, tbl[i].e_pl, tbl[i].e_cnt}));
      adv();
    end
    idle_inputs();

    // Backpressure: sink stalls for 5 cycles right after the first accept.
    begin_session(7'h11, 1);
    ks_valid = 1'b1;
    ks_rand = 1'b1;
    ks_data = N'($urandom);
    for (int i = 0; i < KS_DEPTH; i++) begin
      smp();
      adv();
    end
    ks_valid = 1'b0;
    ks_rand = 1'b0;
    ct_valid = 1'b1;
    ct_data = N'($urandom);
    pt_ready = 1'b0;
    smp();
    check("bp_first_accept", 64'(ct_ready), 64'(1));
    adv();
    ct_data = N'($urandom);
    for (int i = 0; i < 5; i++) begin
      smp();
      check("bp_stall_ct_ready", 64'(ct_ready), 64'(0));
      check("bp_stall_pt_valid", 64'(pt_valid), 64'(1));
      adv();
    end
    pt_ready = 1'b1;
    send_ct(ct_data, 1'b0);
    send_ct(N'($urandom), 1'b0);
    send_ct(N'($urandom), 1'b1);
    wait_idle("bp");
    check("bp_count", 64'(char_count), 64'(4));

    // Starvation: ciphertext waits while no keystream is buffered.
    begin_session(7'h3C, 0);
    ct_valid = 1'b1;
    ct_data = N'($urandom);
    pt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      check("starve_ct_ready", 64'(ct_ready), 64'(0));
      check("starve_pt_valid", 64'(pt_valid), 64'(0));
      adv();
    end
    ks_valid = 1'b1;
    ks_rand = 1'b1;
    ks_data = N'($urandom);
    send_ct(ct_data, 1'b0);
    send_ct(N'($urandom), 1'b0);
    send_ct(N'($urandom), 1'b1);
    ks_rand = 1'b0;
    wait_idle("starve");
    check("starve_count", 64'(char_count), 64'(3));

    // Full buffer, then steady push+pop streaming with a start pulse mid-RUN.
    begin_session(7'h4D, 2);
    pw_old = 7'h4D;
    ks_valid = 1'b1;
    ks_rand = 1'b1;
    ks_data = N'($urandom);
    pushes = 0;
    for (int i = 0; i < 2 * KS_DEPTH; i++) begin
      smp();
      if (ks_valid && ks_ready) pushes++;
      adv();
    end
    check("full_pushes", 64'(pushes), 64'(KS_DEPTH));
    smp();
    check("full_ks_ready", 64'(ks_ready), 64'(0));
    adv();
    ct_valid = 1'b1;
    pt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ct_data = N'($urandom);
      if (i == 3) begin
        start = 1'b1;
        password = 7'h7F;
      end
      smp();
      check("stream_ct_ready", 64'(ct_ready), 64'(1));
      check("stream_occupancy", 64'(m_ks.size()), 64'(KS_DEPTH - 1));
      if (i > 0) check("stream_ks_ready", 64'(ks_ready), 64'(1));
      if (i == 4) begin
        check("run_start_key_load", 64'(key_load), 64'(0));
        check("run_start_key_out", 64'(key_out), 64'(pw_old));
        check("run_start_busy", 64'(busy), 64'(1));
      end
      adv();
      start = 1'b0;
    end
    send_ct(N'($urandom), 1'b1);
    ks_rand = 1'b0;
    wait_idle("stream");
    check("stream_count", 64'(char_count), 64'(9));

    // Reset while a plaintext is in flight.
    begin_session(7'h55, 0);
    ks_valid = 1'b1;
    ks_rand = 1'b1;
    smp(); adv();
    smp(); adv();
    ks_valid = 1'b0;
    ks_rand = 1'b0;
    ct_valid = 1'b1;
    ct_data = N'($urandom);
    pt_ready = 1'b0;
    smp();
    adv();
    check("midrun_pt_pending", 64'(pt_valid), 64'(1));
    apply_reset("midrun");

    // Randomized sessions with random handshakes on all three streams.
    for (int s = 0; s < 6; s++) begin
      len = int'($urandom_range(1, 12));
      begin_session(N'($urandom), int'($urandom_range(0, 3)));
      idx = 0;
      fin = 1'b0;
      for (int c = 0; c < 2000 && !fin; c++) begin
        ks_valid = ($urandom_range(0, 3) != 0);
        ks_data  = N'($urandom);
        ct_valid = (idx < len) && ($urandom_range(0, 2) != 0);
        ct_data  = N'($urandom);
        ct_last  = (idx == len - 1);
        pt_ready = ($urandom_range(0, 2) != 0);
        smp();
        if (ct_valid && ct_ready) idx++;
        if (!busy) fin = 1'b1;
        adv();
      end
      idle_inputs();
      check($sformatf("rand%0d_done", s), 64'(fin), 64'(1));
      check($sformatf("rand%0d_len", s), 64'(idx), 64'(len));
      check($sformatf("rand%0d_count", s), 64'(char_count), 64'(len));
      check($sformatf("rand%0d_exp_drained", s), 64'(m_exp.size()), 64'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

endmodule
